// File: rtl/systolic_skew_feeder.sv
// Skews one N-lane row per accept onto the array's top PE row.
// Lane j delays j+1 cycles; the block drains the skew and pulses done.
module systolic_skew_feeder #(
   parameter int N          = 4,
   parameter int DATA_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    aresetn,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [N*DATA_WIDTH-1:0] s_data,
   input  logic                    s_last,
   output logic [N*DATA_WIDTH-1:0] col_out,
   output logic [N-1:0]            col_valid,
   output logic                    busy,
   output logic                    done,
   output logic [15:0]             beat_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DRAIN
   } state_e;

   localparam int CW = (N > 2) ? $clog2(N) : 1;
   localparam logic [CW-1:0] DRAIN_LOAD = (N >= 2) ? CW'(N - 2) : '0;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          done_q, done_d;
   logic [15:0]   beat_q, beat_d;
   logic          accept;

   assign s_ready  = (state_q != DRAIN);
   assign busy     = (state_q != IDLE);
   assign accept   = s_valid && s_ready;
   assign done     = done_q;
   assign beat_cnt = beat_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      beat_d  = beat_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               beat_d = 16'd1;
               if (!s_last) begin
                  state_d = STREAM;
               end else if (N == 1) begin
                  done_d = 1'b1;
               end else begin
                  state_d = DRAIN;
                  cnt_d   = DRAIN_LOAD;
               end
            end
         end
         STREAM: begin
            if (accept) begin
               if (beat_q != 16'hFFFF) begin
                  beat_d = beat_q + 16'd1;
               end
               if (s_last) begin
                  if (N == 1) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = DRAIN;
                     cnt_d   = DRAIN_LOAD;
                  end
               end
            end
         end
         DRAIN: begin
            // counter holds the number of drain cycles still to come
            if (cnt_q == '0) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         beat_q  <= beat_d;
      end
   end

   for (genvar j = 0; j < N; j++) begin : g_lane
      logic [DATA_WIDTH-1:0] dat_q [j+1];
      logic [DATA_WIDTH-1:0] dat_d [j+1];
      logic [j:0]            vld_q, vld_d;

      always_comb begin
         dat_d[0] = accept ? s_data[j*DATA_WIDTH +: DATA_WIDTH] : '0;
         vld_d[0] = accept;
         for (int k = 1; k <= j; k++) begin
            dat_d[k] = dat_q[k-1];
            vld_d[k] = vld_q[k-1];
         end
      end

      always_ff @(posedge clk or negedge aresetn) begin
         if (!aresetn) begin
            for (int k = 0; k <= j; k++) begin
               dat_q[k] <= '0;
            end
            vld_q <= '0;
         end else begin
            dat_q <= dat_d;
            vld_q <= vld_d;
         end
      end

      assign col_out[j*DATA_WIDTH +: DATA_WIDTH] = dat_q[j];
      assign col_valid[j] = vld_q[j];
   end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder: directed rows in,
// per-lane and done expectations queued, monitor pops on the outputs.
module tb_systolic_skew_feeder;

   localparam int N  = 4;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          aresetn = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_last = 1'b0;
   logic [N*DW-1:0] s_data = '0;
   logic          s_ready;
   logic [N*DW-1:0] col_out;
   logic [N-1:0]  col_valid;
   logic          busy;
   logic          done;
   logic [15:0]   beat_cnt;

   systolic_skew_feeder #(.N(N), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .aresetn   (aresetn),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .col_out   (col_out),
      .col_valid (col_valid),
      .busy      (busy),
      .done      (done),
      .beat_cnt  (beat_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [31:0] cy;
      logic [15:0] d;
   } exp_t;

   exp_t lane_q [N][$];
   exp_t done_q [$];

   int checks = 0;
   int errors = 0;

   // bench-side model of the handshake
   int          drain_left = 0;
   bit          in_matrix = 0;
   logic [15:0] m_beat = '0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h at cycle %0d",
                  nm, act, exp, cyc);
      end
   endtask

   function automatic logic [N*DW-1:0] row(input logic [15:0] a,
      input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
      return {d, c, b, a};
   endfunction

   always @(negedge clk) begin
      exp_t e;
      logic [DW-1:0] lv;
      if (aresetn) begin
         for (int j = 0; j < N; j++) begin
            lv = col_out[j*DW +: DW];
            if (col_valid[j]) begin
               if (lane_q[j].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL lane%0d_unexpected: got %0h want none at cycle %0d",
                           j, lv, cyc);
               end else begin
                  e = lane_q[j].pop_front();
                  chk($sformatf("lane%0d_data", j), 32'(lv), 32'(e.d));
                  chk($sformatf("lane%0d_cycle", j), cyc, e.cy);
               end
            end else begin
               chk($sformatf("lane%0d_bubble", j), 32'(lv), 32'd0);
               if (lane_q[j].size() != 0 && lane_q[j][0].cy <= cyc) begin
                  chk($sformatf("lane%0d_valid", j), 32'(col_valid[j]), 32'd1);
                  void'(lane_q[j].pop_front());
               end
            end
         end
         if (done) begin
            if (done_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL done_unexpected: got 1 want 0 at cycle %0d", cyc);
            end else begin
               e = done_q.pop_front();
               chk("done_cycle", cyc, e.cy);
               chk("done_beat_cnt", 32'(beat_cnt), 32'(e.d));
            end
         end else if (done_q.size() != 0 && done_q[0].cy <= cyc) begin
            chk("done_pulse", 32'(done), 32'd1);
            void'(done_q.pop_front());
         end
      end
   end

   task automatic drive(input logic v, input logic last,
                        input logic [N*DW-1:0] d);
      bit rdy;
      bit acc;
      exp_t e;
      @(negedge clk);
      #1;
      s_valid = v;
      s_last  = last;
      s_data  = d;
      rdy = (drain_left == 0);
      chk("s_ready", 32'(s_ready), 32'(rdy));
      chk("busy", 32'(busy), 32'(in_matrix || drain_left > 0));
      chk("beat_cnt", 32'(beat_cnt), 32'(m_beat));
      acc = v && rdy;
      if (drain_left > 0) drain_left--;
      if (acc) begin
         if (!in_matrix) m_beat = 16'd1;
         else if (m_beat != 16'hFFFF) m_beat = m_beat + 16'd1;
         in_matrix = !last;
         for (int j = 0; j < N; j++) begin
            e.cy = cyc + 1 + j;
            e.d  = d[j*DW +: DW];
            lane_q[j].push_back(e);
         end
         if (last) begin
            drain_left = N - 1;
            e.cy = cyc + N;
            e.d  = m_beat;
            done_q.push_back(e);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_col_out"}, 32'(col_out != '0), 32'd0);
      chk({tag, "_col_valid"}, 32'(col_valid), 32'd0);
      chk({tag, "_beat_cnt"}, 32'(beat_cnt), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_s_ready"}, 32'(s_ready), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic clear_model();
      for (int j = 0; j < N; j++) lane_q[j].delete();
      done_q.delete();
      drain_left = 0;
      in_matrix  = 0;
      m_beat     = '0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #1;
      check_reset_state("reset");
      aresetn = 1'b1;

      // single-row matrix
      drive(1'b1, 1'b1, row(1, 2, 3, 4));
      idle(5);

      // three back-to-back rows
      drive(1'b1, 1'b0, row(10, 11, 12, 13));
      drive(1'b1, 1'b0, row(20, 21, 22, 23));
      drive(1'b1, 1'b1, row(30, 31, 32, 33));
      idle(5);

      // bubble between two rows
      drive(1'b1, 1'b0, row(40, 41, 42, 43));
      drive(1'b0, 1'b0, row(99, 99, 99, 99));
      drive(1'b1, 1'b1, row(50, 51, 52, 53));
      idle(5);

      // s_valid held through drain; the 7s row lands on the done cycle
      drive(1'b1, 1'b1, row(5, 6, 7, 8));
      for (int i = 0; i < N; i++) drive(1'b1, 1'b1, row(7, 7, 7, 7));
      idle(5);

      // reset in the middle of DRAIN
      drive(1'b1, 1'b0, row(60, 61, 62, 63));
      drive(1'b1, 1'b1, row(70, 71, 72, 73));
      drive(1'b0, 1'b0, '0);
      @(negedge clk);
      #1;
      aresetn = 1'b0;
      #1;
      check_reset_state("abort");
      clear_model();
      @(negedge clk);
      @(negedge clk);
      #1;
      check_reset_state("abort_hold");
      aresetn = 1'b1;
      drive(1'b1, 1'b1, row(9, 8, 7, 6));
      idle(6);

      for (int j = 0; j < N; j++)
         chk($sformatf("lane%0d_left", j), lane_q[j].size(), 0);
      chk("done_left", done_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got no finish want finish at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
